rotate_sequencer: RTL and testbench

Generates the 3-bit rotation select (selc) that drives the five-digit rotating character display one stage downstream. Free-runs the rotation at a programmable tick rate, or pauses and single-steps from a pushbutton. Direction is selectable. Raw board switches and keys enter through internal synchronisers.

---
 rtl/rotate_sequencer_pkg.sv | 26 ++
 rtl/rot_sync.sv | 54 +++++
 rtl/rotate_sequencer.sv | 152 +++++++++++++++
 tb/tb_rotate_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rotate_sequencer_pkg.sv
// ============================================================================
// Module      : rotate_pkg
// Description : Shared widths, FSM state type and sizing helper for the
//               rotation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rotate_pkg;

    localparam int SEL_W       = 3;
    localparam int NUM_POS_MAX = 8;

    typedef enum logic [0:0] {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Prescaler width for a divide-by-div counter; never narrower than 1 bit.
    function automatic int presc_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rot_sync.sv
// ============================================================================
// Module      : rot_sync
// Description : Two-flop synchroniser for an asynchronous board input, with an
//               optional rising-edge pulse on the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rot_sync #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_dly;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= 1'b0;
                end else begin
                    r_dly <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_dly;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rotate_sequencer.sv
// ============================================================================
// Module      : rotate_sequencer
// Description : Rotation-select generator for the five-digit rotating display;
//               free-runs at TICK_DIV or single-steps while paused.
//               Optional step debounce: define ROTATE_STEP_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int NUM_POS    = 5,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic             clr,
    output logic [SEL_W-1:0] selc,
    output logic             tick,
    output logic             running
);

    localparam int                   c_PRESC_W    = presc_width(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0]     c_POS_LAST   = SEL_W'(NUM_POS - 1);

    logic                 w_run_s;
    logic                 w_step_s;
    logic                 w_step_edge;
    logic                 w_step_rise;
    logic                 w_dir_s;
    logic                 w_clr_s;
    logic [2:0]           w_unused_rise;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_PRESC_W-1:0] w_presc_nxt;
    logic [SEL_W-1:0]     r_selc;
    logic [SEL_W-1:0]     w_selc_nxt;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 r_running;
    logic                 w_adv;

    rot_sync #(.EDGE_EN(1'b0)) u_sync_run (
        .clk(clk), .rst_n(rst_n), .i_async(run),  .o_sync(w_run_s),  .o_rise(w_unused_rise[0])
    );
    rot_sync #(.EDGE_EN(1'b0)) u_sync_dir (
        .clk(clk), .rst_n(rst_n), .i_async(dir),  .o_sync(w_dir_s),  .o_rise(w_unused_rise[1])
    );
    rot_sync #(.EDGE_EN(1'b0)) u_sync_clr (
        .clk(clk), .rst_n(rst_n), .i_async(clr),  .o_sync(w_clr_s),  .o_rise(w_unused_rise[2])
    );
    rot_sync #(.EDGE_EN(1'b1)) u_sync_step (
        .clk(clk), .rst_n(rst_n), .i_async(step), .o_sync(w_step_s), .o_rise(w_step_edge)
    );

`ifdef ROTATE_STEP_DEBOUNCE_EN
    localparam int               c_DEB_W   = $clog2(DEB_CYCLES + 2);
    localparam logic [c_DEB_W-1:0] c_DEB_HIT = c_DEB_W'(DEB_CYCLES);
    localparam logic [c_DEB_W-1:0] c_DEB_SAT = c_DEB_W'(DEB_CYCLES + 1);

    logic [c_DEB_W-1:0] r_deb_cnt;
    logic               w_step_edge_unused;

    assign w_step_edge_unused = w_step_edge;

    // Counter saturates one past the hit value so a held press fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
        end else if (!w_step_s) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != c_DEB_SAT) begin
            r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
        end
    end

    assign w_step_rise = w_step_s && (r_deb_cnt == c_DEB_HIT);
`else
    localparam int c_deb_unused = DEB_CYCLES;

    assign w_step_rise = w_step_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PAUSE;
            r_presc   <= '0;
            r_selc    <= '0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_selc    <= w_selc_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_presc_nxt = '0;
        w_selc_nxt  = r_selc;
        w_tick_nxt  = 1'b0;

        case (r_state)
            PAUSE: begin
                w_adv = w_step_rise;
                if (w_run_s) w_state_nxt = RUN;
            end
            RUN: begin
                w_adv = (r_presc == c_PRESC_LAST);
                if (!w_run_s) w_state_nxt = PAUSE;
            end
            default: w_state_nxt = PAUSE;
        endcase

        // Prescaler restarts from zero on any state change and under clear.
        if ((r_state == RUN) && (w_state_nxt == RUN) && !w_clr_s) begin
            w_presc_nxt = (r_presc == c_PRESC_LAST) ? '0 : r_presc + c_PRESC_W'(1);
        end

        if (w_clr_s) begin
            w_selc_nxt = '0;
        end else if (r_selc > c_POS_LAST) begin
            w_selc_nxt = '0;
        end else if (w_adv) begin
            w_tick_nxt = 1'b1;
            if (w_dir_s) begin
                w_selc_nxt = (r_selc == '0) ? c_POS_LAST : r_selc - SEL_W'(1);
            end else begin
                w_selc_nxt = (r_selc == c_POS_LAST) ? '0 : r_selc + SEL_W'(1);
            end
        end
    end

    assign selc    = r_selc;
    assign tick    = r_tick;
    assign running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
// ============================================================================
// Module      : tb_rotate_sequencer
// Description : Randomised self-checking bench for rotate_sequencer against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotate_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int NUM_POS    = 5;
    localparam int DEB_CYCLES = 8;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       dir;
    logic       clr;
    logic [2:0] selc;
    logic       tick;
    logic       running;

    int checks = 0;
    int errors = 0;

    rotate_sequencer #(
        .TICK_DIV(TICK_DIV), .NUM_POS(NUM_POS), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .dir(dir), .clr(clr),
        .selc(selc), .tick(tick), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: inputs become visible two edges late; a step edge
    // compares the synchronised level with its value one edge earlier.
    logic [2:0] h_run, h_step, h_dir, h_clr;
    int  m_pos;
    int  m_phase;
    int  m_hi;
    bit  m_tick;
    bit  m_running;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_run = '0; h_step = '0; h_dir = '0; h_clr = '0;
            m_pos = 0; m_phase = 0; m_hi = 0; m_tick = 0; m_running = 0;
        end else begin
            bit run_s, step_s, step_d, dir_s, clr_s, rise, adv;
            run_s  = h_run[1];
            step_s = h_step[1];
            step_d = h_step[2];
            dir_s  = h_dir[1];
            clr_s  = h_clr[1];
`ifdef ROTATE_STEP_DEBOUNCE_EN
            rise = step_s && (m_hi == DEB_CYCLES);
            m_hi = step_s ? m_hi + 1 : 0;
`else
            rise = step_s && !step_d;
`endif
            adv = m_running ? (m_phase == TICK_DIV - 1) : rise;
            if (clr_s) begin
                m_pos  = 0;
                m_tick = 0;
            end else if (adv) begin
                m_pos  = dir_s ? (m_pos + NUM_POS - 1) % NUM_POS : (m_pos + 1) % NUM_POS;
                m_tick = 1;
            end else begin
                m_tick = 0;
            end
            if (clr_s || !run_s || (run_s != m_running)) m_phase = 0;
            else m_phase = (m_phase + 1) % TICK_DIV;
            m_running = run_s;
            h_run  = {h_run[1:0], run};
            h_step = {h_step[1:0], step};
            h_dir  = {h_dir[1:0], dir};
            h_clr  = {h_clr[1:0], clr};
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    int tick_cnt = 0;

    task automatic cyc();
        @(negedge clk);
        chk_val("selc", 32'(selc), 32'(m_pos));
        chk_val("tick", 32'(tick), 32'(m_tick));
        chk_val("running", 32'(running), 32'(m_running));
        if (tick === 1'b1) tick_cnt++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int base;
        bit found;
        rst_n = 1'b0; run = 0; step = 0; dir = 0; clr = 0;
        cycles(3);
        rst_n = 1'b1;

        // Idle, paused: nothing moves.
        base = tick_cnt;
        cycles(100);
        chk_val("idle_ticks", 32'(tick_cnt - base), 32'd0);

        // Auto-rotate forward, then reverse, then random direction flips.
        run = 1; dir = 0;
        cycles(26);
        dir = 1;
        cycles(26);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 6) == 0) dir = ~dir;
            cyc();
        end

        // Paused single steps.
        run = 0; dir = 0;
        cycles(8);
        for (int p = 0; p < 3; p++) begin
            step = 1; cycles(5);
            step = 0; cycles(6);
        end
        base = tick_cnt;
        step = 1; cycles(50);
        step = 0; cycles(10);
`ifndef ROTATE_STEP_DEBOUNCE_EN
        chk_val("hold_ticks", 32'(tick_cnt - base), 32'd1);
`endif

        // Clear while running.
        run = 1;
        cycles(15);
        clr = 1; cycles(10);
        clr = 0; cycles(20);

`ifdef ROTATE_STEP_DEBOUNCE_EN
        run = 0;
        cycles(8);
        base = tick_cnt;
        for (int i = 0; i < 10; i++) begin
            step = ~step; cycles(3);
        end
        step = 0; cycles(5);
        chk_val("bounce_ticks", 32'(tick_cnt - base), 32'd0);
        base = tick_cnt;
        step = 1; cycles(20);
        step = 0; cycles(5);
        chk_val("deb_press_ticks", 32'(tick_cnt - base), 32'd1);
`endif

        // Random mix of all inputs.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) run  = ~run;
            if ($urandom_range(0, 4)  == 0) step = ~step;
            if ($urandom_range(0, 15) == 0) dir  = ~dir;
            if ($urandom_range(0, 30) == 0) clr  = 1;
            else if ($urandom_range(0, 3) == 0) clr = 0;
            cyc();
        end

        // Asynchronous reset mid-count, with the prescaler at 2.
        run = 1; step = 0; clr = 0; dir = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (m_running && m_phase == 2 && m_pos != 0) found = 1;
        end
        chk_val("presc_wait", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_val("arst_selc", 32'(selc), 32'd0);
        chk_val("arst_running", 32'(running), 32'd0);
        chk_val("arst_tick", 32'(tick), 32'd0);
        #1 rst_n = 1'b1;
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
